// File: rtl/packeter_pkg.sv
// Shared constants, FSM state type and CRC-8 helper for the sample packeter.
package packeter_pkg;

  localparam logic [7:0]  SYNC_BYTE      = 8'hA5;
  localparam int unsigned TYPE_EVENT_BIT = 7;
  localparam int unsigned FLAG_SOVF_BIT  = 0;
  localparam int unsigned FLAG_EOVF_BIT  = 1;
  localparam logic [7:0]  CRC8_POLY      = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_TYPE,
    ST_SEQ,
    ST_PAYLOAD,
    ST_CRC
  } pkt_state_t;

  // CRC-8, MSB first, no reflection: fold one byte into the running remainder.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/packeter_fifo.sv
// Synchronous show-ahead byte FIFO; occupancy comes from extended-width pointers.
module packeter_fifo #(
  parameter int unsigned DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     wr_en,
  input  logic [7:0]               din,
  input  logic                     rd_en,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic          wr_ok, rd_ok;

  assign full  = (count == PW'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_comb begin
    wr_ptr_nxt = wr_ptr + PW'(wr_ok);
    rd_ptr_nxt = rd_ptr + PW'(rd_ok);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= wr_ptr_nxt - rd_ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sample_packeter.sv
// Frames buffered sample bytes and latched events into A5/TYPE/SEQ packets.
// Define PACKETER_CRC_EN to append a CRC-8 trailer after each payload.
module sample_packeter
  import packeter_pkg::*;
#(
  parameter int unsigned PAYLOAD_LEN = 192,
  parameter int unsigned FIFO_DEPTH  = 512
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       sample_valid,
  input  logic [7:0] sample_data,
  input  logic       event_valid,
  input  logic [7:0] event_data,
  output logic       out_valid,
  output logic [7:0] out_data
);

  localparam int unsigned   CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] PL_COUNT = CW'(PAYLOAD_LEN);
  localparam logic [7:0]    PL_LAST  = 8'(PAYLOAD_LEN - 1);

  pkt_state_t    state, state_nxt;
  logic          is_event;
  logic [7:0]    seq, pay_cnt, ev_data, byte_nxt, type_byte;
  logic          ev_pending, sovf, eovf;
  logic          pkt_done, fifo_rd, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_dout;
`ifdef PACKETER_CRC_EN
  logic [7:0]    crc;
`endif

  packeter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .nreset (nreset),
    .wr_en  (sample_valid),
    .din    (sample_data),
    .rd_en  (fifo_rd),
    .dout   (fifo_dout),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    type_byte = '0;
    type_byte[TYPE_EVENT_BIT] = is_event;
    type_byte[FLAG_SOVF_BIT]  = sovf;
    type_byte[FLAG_EOVF_BIT]  = eovf;
  end

  // byte_nxt is the byte shown on out_data after the coming edge.
  always_comb begin
    state_nxt = state;
    byte_nxt  = '0;
    fifo_rd   = 1'b0;
    pkt_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ev_pending || fifo_count >= PL_COUNT) state_nxt = ST_SYNC;
      end
      ST_SYNC: begin
        byte_nxt  = SYNC_BYTE;
        state_nxt = ST_TYPE;
      end
      ST_TYPE: begin
        byte_nxt  = type_byte;
        state_nxt = ST_SEQ;
      end
      ST_SEQ: begin
        byte_nxt  = seq;
        state_nxt = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (is_event) begin
          byte_nxt = ev_data;
        end else begin
          byte_nxt = fifo_dout;
          fifo_rd  = !fifo_empty;
        end
        if (is_event || pay_cnt == PL_LAST) begin
`ifdef PACKETER_CRC_EN
          state_nxt = ST_CRC;
`else
          state_nxt = ST_IDLE;
          pkt_done  = 1'b1;
`endif
        end
      end
`ifdef PACKETER_CRC_EN
      ST_CRC: begin
        byte_nxt  = crc;
        state_nxt = ST_IDLE;
        pkt_done  = 1'b1;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= ST_IDLE;
      is_event  <= 1'b0;
      pay_cnt   <= '0;
      seq       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state != ST_IDLE);
      out_data  <= byte_nxt;
      if (state == ST_IDLE) is_event <= ev_pending;
      pay_cnt   <= (state == ST_PAYLOAD) ? pay_cnt + 8'd1 : '0;
      if (pkt_done) seq <= seq + 8'd1;
    end
  end

  // The latch is judged on its pre-edge state, so an event arriving while the
  // latched one is being emitted still counts as an overflow.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ev_pending <= 1'b0;
      ev_data    <= '0;
      sovf       <= 1'b0;
      eovf       <= 1'b0;
    end else begin
      if (state == ST_PAYLOAD && is_event) ev_pending <= 1'b0;
      if (event_valid && !ev_pending) begin
        ev_pending <= 1'b1;
        ev_data    <= event_data;
      end
      sovf <= (sovf && state != ST_TYPE) || (sample_valid && fifo_full);
      eovf <= (eovf && state != ST_TYPE) || (event_valid && ev_pending);
    end
  end

`ifdef PACKETER_CRC_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      crc <= '0;
    end else if (state == ST_IDLE) begin
      crc <= '0;
    end else if (state != ST_CRC) begin
      crc <= crc8_update(crc, byte_nxt);
    end
  end
`endif

endmodule

// File: tb/tb_sample_packeter.sv
// Self-checking bench for sample_packeter: directed scenarios plus random traffic vs a packet-level model.
module tb_sample_packeter;

  localparam int PL    = 6;
  localparam int DEPTH = 16;
`ifdef PACKETER_CRC_EN
  localparam int CRC_LEN = 1;
`else
  localparam int CRC_LEN = 0;
`endif
  localparam int PS = 3 + PL + CRC_LEN;
  localparam int PE = 4 + CRC_LEN;

  logic       clk = 1'b0;
  logic       nreset;
  logic       sample_valid, event_valid, out_valid;
  logic [7:0] sample_data, event_data, out_data;

  sample_packeter #(.PAYLOAD_LEN(PL), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .nreset       (nreset),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .event_valid  (event_valid),
    .event_data   (event_data),
    .out_valid    (out_valid),
    .out_data     (out_data)
  );

  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Packet-level reference model state
  logic [7:0] mq[$];
  bit         m_ev_full, m_sovf, m_eovf, m_busy, m_pkt_ev;
  logic [7:0] m_ev_byte, m_seq, m_crc;
  int         m_pos;
  logic [7:0] seen[$];
  logic [7:0] seq_log[$];
  logic [7:0] type_log[$];

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit sv, input logic [7:0] sd, input bit evv, input logic [7:0] ed);
    bit         exp_v, full_pre, ev_full_pre, emit_type, emit_ev, sset, eset;
    logic [7:0] exp_d;
    int         plen, pos_now;
    sample_valid = sv; sample_data = sd; event_valid = evv; event_data = ed;
    full_pre    = (mq.size() == DEPTH);
    ev_full_pre = m_ev_full;
    emit_type = 0; emit_ev = 0; exp_v = 0; exp_d = '0; pos_now = -1;
    if (!m_busy) begin
      if (m_ev_full || mq.size() >= PL) begin
        m_busy = 1; m_pos = 0; m_pkt_ev = m_ev_full; m_crc = '0;
      end
    end else begin
      plen    = m_pkt_ev ? 1 : PL;
      exp_v   = 1;
      pos_now = m_pos;
      if (m_pos == 0) exp_d = 8'hA5;
      else if (m_pos == 1) begin exp_d = {m_pkt_ev, 5'b0, m_eovf, m_sovf}; emit_type = 1; end
      else if (m_pos == 2) exp_d = m_seq;
      else if (m_pos < 3 + plen) begin
        if (m_pkt_ev) begin exp_d = m_ev_byte; emit_ev = 1; end
        else exp_d = mq.pop_front();
      end else exp_d = m_crc;
      if (m_pos < 3 + plen) m_crc = crc8(m_crc, exp_d);
      m_pos++;
      if (m_pos == 3 + plen + CRC_LEN) begin m_busy = 0; m_seq = m_seq + 8'd1; end
    end
    sset = sv && full_pre;
    if (sv && !full_pre) mq.push_back(sd);
    eset = evv && ev_full_pre;
    if (emit_ev) m_ev_full = 0;
    if (evv && !ev_full_pre) begin m_ev_full = 1; m_ev_byte = ed; end
    if (emit_type) begin m_sovf = sset; m_eovf = eset; end
    else begin m_sovf = m_sovf | sset; m_eovf = m_eovf | eset; end
    @(posedge clk); #1;
    check("out_valid", out_valid, exp_v);
    if (exp_v) begin
      check("out_data", out_data, exp_d);
      seen.push_back(out_data);
      if (pos_now == 1) type_log.push_back(out_data);
      if (pos_now == 2) seq_log.push_back(out_data);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 8'h00, 0, 8'h00);
  endtask

  initial begin
    logic [7:0] ref_bytes [9];
    logic [7:0] c;
    bit         found;
    int         base;
    sample_valid = 0; sample_data = 0; event_valid = 0; event_data = 0;
    mq.delete(); m_ev_full = 0; m_sovf = 0; m_eovf = 0; m_busy = 0; m_pkt_ev = 0;
    m_ev_byte = 0; m_seq = 0; m_crc = 0; m_pos = 0;

    // 1. Reset
    nreset = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    nreset = 1;
    idle(10);

    // 2. Two sample packets
    seen.delete();
    for (int i = 1; i <= 6; i++) tick(1, 8'(i), 0, 8'h00);
    idle(15);
    ref_bytes = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    for (int i = 0; i < 9; i++) check($sformatf("pkt0_byte%0d", i), seen[i], ref_bytes[i]);
`ifdef PACKETER_CRC_EN
    // 6. CRC trailer over SYNC..payload
    c = 8'h00;
    for (int i = 0; i < 9; i++) c = crc8(c, ref_bytes[i]);
    check("crc_trailer", seen[9], c);
`endif
    for (int i = 7; i <= 12; i++) tick(1, 8'(i), 0, 8'h00);
    idle(15);
    check("pkt_bytes_total", seen.size(), 2 * PS);
    check("pkt1_seq", seen[PS + 2], 8'h01);

    // 3a. Event while idle
    seen.delete();
    tick(0, 8'h00, 1, 8'h3C);
    idle(8);
    check("evt_sync", seen[0], 8'hA5);
    check("evt_type", seen[1], 8'h80);
    check("evt_seq", seen[2], 8'h02);
    check("evt_data", seen[3], 8'h3C);

    // 3b. Event mid sample packet jumps ahead of the queued sample packet
    seen.delete();
    for (int i = 1; i <= 12; i++) tick(1, 8'(i), (i == 8), 8'h3C);
    idle(30);
    check("mid_evt_type", seen[PS + 1], 8'h80);
    check("mid_evt_data", seen[PS + 3], 8'h3C);
    check("after_evt_type", seen[PS + PE + 1], 8'h00);
    check("after_evt_first", seen[PS + PE + 3], 8'h07);

    // 4. Back-to-back events during a packet
    seen.delete();
    for (int i = 1; i <= 6; i++) tick(1, 8'(8'h40 + i), 0, 8'h00);
    idle(3);
    tick(0, 8'h00, 1, 8'h11);
    tick(0, 8'h00, 1, 8'h22);
    idle(20);
    for (int i = 1; i <= 6; i++) tick(1, 8'(8'h50 + i), 0, 8'h00);
    idle(15);
    check("evovf_type", seen[PS + 1], 8'h82);
    check("evovf_data", seen[PS + 3], 8'h11);
    check("evovf_cleared", seen[PS + PE + 1], 8'h00);
    check("evovf_bytes", seen.size(), 2 * PS + PE);

    // 5. FIFO overfill at one byte per cycle
    type_log.delete();
    for (int i = 0; i < 40; i++) tick(1, 8'(i), 0, 8'h00);
    idle(60);
    found = 0;
    foreach (type_log[i]) if (type_log[i][0]) found = 1;
    check("sovf_reported", found, 1'b1);

    // Random traffic, long enough to wrap SEQ
    for (int i = 0; i < 4000; i++)
      tick(bit'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 19) == 0), 8'($urandom));
    idle(60);
    found = 0;
    base = seq_log.size();
    for (int i = 1; i < base; i++)
      if (seq_log[i-1] == 8'hFF && seq_log[i] == 8'h00) found = 1;
    check("seq_wrap", found, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
